// File: rtl/altusoc_gpio_in_cond.sv
// GPIO input conditioning: per-bit 2-flop synchronizer, stability-counter debouncer,
// edge detector and sticky pending flags OR-ed into one interrupt.
// Optional per-bit glitch counters are enabled by defining ALTUSOC_GPIO_GLITCH_CNT_EN.
module altusoc_gpio_in_cond #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     i_pad,
  input  logic [WIDTH-1:0]     i_rise_en,
  input  logic [WIDTH-1:0]     i_fall_en,
  input  logic [WIDTH-1:0]     i_pend_clr,
  output logic [WIDTH-1:0]     o_gpio,
  output logic [WIDTH-1:0]     o_rise,
  output logic [WIDTH-1:0]     o_fall,
  output logic [WIDTH-1:0]     o_pend,
  output logic                 o_irq,
  output logic [8*WIDTH-1:0]   o_glitch_cnt
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] lvl_q, lvl_d_q;
  logic [WIDTH-1:0] pend_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];

  // Plain two-stage synchronizer: nothing may sit between s1_q and s2_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      // NOTE: non-blocking so s2_q takes the old s1_q; blocking would collapse both stages into one.
      s1_q <= i_pad;
      s2_q <= s1_q;
    end
  end

  // Level changes only after DEBOUNCE_CYCLES consecutive mismatching samples;
  // any matching sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      // NOTE: counter array is reset entry by entry; these are flops, not a RAM, and must start at 0.
      for (int n = 0; n < WIDTH; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        if (s2_q[n] == lvl_q[n]) begin
          cnt_q[n] <= '0;
        end else if (cnt_q[n] == CNT_MAX) begin
          lvl_q[n] <= s2_q[n];
          cnt_q[n] <= '0;
        end else begin
          cnt_q[n] <= cnt_q[n] + CNT_W'(1);
        end
      end
    end
  end

  assign o_gpio = lvl_q;
  assign o_rise = lvl_q & ~lvl_d_q;
  assign o_fall = ~lvl_q & lvl_d_q;

  // Set takes priority over clear so an edge coinciding with a clear is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d_q <= '0;
      pend_q  <= '0;
    end else begin
      lvl_d_q <= lvl_q;
      pend_q  <= (pend_q & ~i_pend_clr) | (o_rise & i_rise_en) | (o_fall & i_fall_en);
    end
  end

  assign o_pend = pend_q;
  assign o_irq  = |pend_q;

`ifdef ALTUSOC_GPIO_GLITCH_CNT_EN
  logic [7:0] glitch_q [WIDTH];

  // An aborted debounce attempt is a match sample arriving while the count is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < WIDTH; n++) glitch_q[n] <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) begin
        if (s2_q[n] == lvl_q[n] && cnt_q[n] != '0 && glitch_q[n] != 8'hFF)
          glitch_q[n] <= glitch_q[n] + 8'd1;
      end
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives every bit and no latch is inferred.
    o_glitch_cnt = '0;
    for (int n = 0; n < WIDTH; n++) o_glitch_cnt[8*n +: 8] = glitch_q[n];
  end
`else
  assign o_glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_altusoc_gpio_in_cond.sv
// Bench for altusoc_gpio_in_cond: directed vector table, multi-cycle corner sequences
// and a randomized phase checked against a behavioural model of the conditioning rules.
module tb_altusoc_gpio_in_cond;

  localparam int W = 4;
  localparam int D = 16;
`ifdef ALTUSOC_GPIO_GLITCH_CNT_EN
  localparam bit GLITCH_ON = 1'b1;
`else
  localparam bit GLITCH_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] pad = '0, ren = '0, fen = '0, clr = '0;
  logic [W-1:0] gpio, rise, fall, pend;
  logic         irq;
  logic [8*W-1:0] glitch;

  logic [0:0]   gpio1, rise1, fall1, pend1;
  logic         irq1;
  logic [7:0]   glitch1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  altusoc_gpio_in_cond #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_pad(pad), .i_rise_en(ren), .i_fall_en(fen),
    .i_pend_clr(clr), .o_gpio(gpio), .o_rise(rise), .o_fall(fall), .o_pend(pend),
    .o_irq(irq), .o_glitch_cnt(glitch)
  );

  // Minimum-debounce instance: synchronizer plus one cycle.
  altusoc_gpio_in_cond #(.WIDTH(1), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_pad(pad[0:0]), .i_rise_en(1'b0), .i_fall_en(1'b0),
    .i_pend_clr(1'b0), .o_gpio(gpio1), .o_rise(rise1), .o_fall(fall1), .o_pend(pend1),
    .o_irq(irq1), .o_glitch_cnt(glitch1)
  );

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_padq[$];
  logic [W-1:0] m_lvl, m_lvl_d, m_pend;
  int           m_run[W];
  int           m_glitch[W];

  task automatic model_reset();
    m_padq.delete();
    m_lvl = '0; m_lvl_d = '0; m_pend = '0;
    for (int b = 0; b < W; b++) begin m_run[b] = 0; m_glitch[b] = 0; end
  endtask

  // One clock edge: the synchronized sample is the pad value seen two edges earlier.
  task automatic model_step();
    logic [W-1:0] s2, r, f;
    s2 = (m_padq.size() >= 2) ? m_padq[m_padq.size()-2] : '0;
    m_padq.push_back(pad);
    if (m_padq.size() > 2) void'(m_padq.pop_front());
    r = m_lvl & ~m_lvl_d;
    f = ~m_lvl & m_lvl_d;
    m_pend  = (m_pend & ~clr) | (r & ren) | (f & fen);
    m_lvl_d = m_lvl;
    for (int b = 0; b < W; b++) begin
      if (s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin m_lvl[b] = s2[b]; m_run[b] = 0; end
      end else begin
        if (m_run[b] > 0 && m_glitch[b] < 255) m_glitch[b]++;
        m_run[b] = 0;
      end
    end
  endtask

  function automatic logic [31:0] model_glitch();
    logic [31:0] g;
    g = '0;
    if (GLITCH_ON)
      for (int b = 0; b < W; b++) g[8*b +: 8] = 8'(m_glitch[b]);
    return g;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] pad, ren, fen, clr;
    int           cyc;
    logic [W-1:0] gpio, rise, fall, pend;
    logic         irq;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int lat0, lat1, rise_seen, high_seen;

    // pad, rise_en, fall_en, clr, cycles, then expected gpio, rise, fall, pend, irq
    tbl.push_back('{4'h0, 4'h1, 4'h0, 4'h0, 100, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h0, 4'h0,  17, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h0, 4'h0,   1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h0, 4'h0,   1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b1});
    tbl.push_back('{4'h1, 4'h1, 4'h0, 4'h1,   1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h0, 4'h1,   5, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h3, 4'h1, 4'h0, 4'h0,  10, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h0, 4'h0,  30, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h5, 4'h1, 4'h4, 4'h0,  18, 4'h5, 4'h4, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h5, 4'h1, 4'h4, 4'h0,   1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h4, 4'h0,  17, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h4, 4'h0,   1, 4'h1, 4'h0, 4'h4, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h4, 4'h4,   1, 4'h1, 4'h0, 4'h0, 4'h4, 1'b1});
    tbl.push_back('{4'h1, 4'h1, 4'h4, 4'h4,   1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
    tbl.push_back('{4'h1, 4'h1, 4'h4, 4'h0,   3, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});

    // Reset
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    check("reset gpio",   32'(gpio),  32'h0);
    check("reset pend",   32'(pend),  32'h0);
    check("reset irq",    32'(irq),   32'h0);
    check("reset glitch", glitch,     32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      pad = tbl[i].pad; ren = tbl[i].ren; fen = tbl[i].fen; clr = tbl[i].clr;
      repeat (tbl[i].cyc) tick();
      check($sformatf("vec%0d gpio", i), 32'(gpio), 32'(tbl[i].gpio));
      check($sformatf("vec%0d rise", i), 32'(rise), 32'(tbl[i].rise));
      check($sformatf("vec%0d fall", i), 32'(fall), 32'(tbl[i].fall));
      check($sformatf("vec%0d pend", i), 32'(pend), 32'(tbl[i].pend));
      check($sformatf("vec%0d irq", i),  32'(irq),  32'(tbl[i].irq));
    end
    clr = '0;
    check("single glitch count", glitch, GLITCH_ON ? 32'h0000_0100 : 32'h0);

    // 300 short pulses on bit 1: never accepted, glitch counter saturates
    rise_seen = 0; high_seen = 0;
    for (int g = 0; g < 300; g++) begin
      pad[1] = 1'b1;
      repeat (10) begin tick(); rise_seen += int'(rise[1]); high_seen += int'(gpio[1]); end
      pad[1] = 1'b0;
      repeat (10) begin tick(); rise_seen += int'(rise[1]); high_seen += int'(gpio[1]); end
    end
    check("glitch burst rise", 32'(rise_seen), 32'h0);
    check("glitch burst gpio", 32'(high_seen), 32'h0);
    check("glitch saturate",   glitch, GLITCH_ON ? 32'h0000_FF00 : 32'h0);

    // Pad 3 high, reset pulsed mid-debounce, then the rise must still be detected
    pad = 4'b1001;
    repeat (9) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst gpio", 32'(gpio), 32'h0);
    check("midrst rise", 32'(rise), 32'h0);
    check("midrst pend", 32'(pend), 32'h0);
    check("midrst irq",  32'(irq),  32'h0);
    check("midrst glitch", glitch,  32'h0);
    tick(); tick(); tick();
    check("inrst gpio", 32'(gpio), 32'h0);
    rst_n = 1'b1;
    lat0 = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (gpio[3]) begin lat0 = n; break; end
    end
    check("post-reset latency", 32'(lat0), 32'(2 + D));
    check("post-reset rise",    32'(rise), 32'h9);

    // Loopback: a written level returns on o_gpio after the conditioning latency
    for (int k = 0; k < 2; k++) begin
      logic tgt;
      tgt = (k == 1);
      pad[0] = tgt;
      lat0 = -1; lat1 = -1;
      for (int n = 1; n <= 40; n++) begin
        tick();
        if (lat0 < 0 && gpio[0] == tgt)  lat0 = n;
        if (lat1 < 0 && gpio1[0] == tgt) lat1 = n;
        if (lat0 >= 0 && lat1 >= 0) break;
      end
      check($sformatf("loopback%0d latency", k),      32'(lat0), 32'(2 + D));
      check($sformatf("loopback%0d latency d1", k),   32'(lat1), 32'd3);
    end
    check("d1 pend idle", {31'h0, pend1[0] | irq1}, 32'h0);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin ren = W'($urandom); fen = W'($urandom); end
      for (int b = 0; b < W; b++) if ($urandom_range(0, 11) == 0) pad[b] = ~pad[b];
      clr = W'($urandom & $urandom & $urandom);
      tick();
      check($sformatf("rnd%0d gpio", i),   32'(gpio), 32'(m_lvl));
      check($sformatf("rnd%0d rise", i),   32'(rise), 32'(m_lvl & ~m_lvl_d));
      check($sformatf("rnd%0d fall", i),   32'(fall), 32'(~m_lvl & m_lvl_d));
      check($sformatf("rnd%0d pend", i),   32'(pend), 32'(m_pend));
      check($sformatf("rnd%0d irq", i),    32'(irq),  32'(|m_pend));
      check($sformatf("rnd%0d glitch", i), glitch,    model_glitch());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/altusoc_gpio_in_cond.md
Name: altusoc_gpio_in_cond

Overview:
- Input-conditioning stage directly upstream of the SoC core's `i_gpio` port.
- Per bit, the raw pad inputs pass through three steps:
  - a 2-flop synchronizer;
  - a stability-counter debouncer;
  - an edge detector.
- The debounced level drives the core's `i_gpio`.
- Rise/fall events set sticky pending flags. These are OR-ed into one level interrupt for the core's external-interrupt input.

Parameters:
- WIDTH, 4: number of GPIO bits conditioned, range 1..32.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized bit must differ from the current debounced level before it is accepted, range 1..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each debounce counter. Localparam, not overridable.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronized externally.
- i_pad  in  WIDTH  raw asynchronous pad levels.
- i_rise_en  in  WIDTH  per-bit enable: rising debounced edge sets the pending flag.
- i_fall_en  in  WIDTH  per-bit enable: falling debounced edge sets the pending flag.
- i_pend_clr  in  WIDTH  per-bit clear pulses, sampled every cycle; 1 clears the flag.
- o_gpio  out  WIDTH  debounced level, connects to core `i_gpio`.
- o_rise  out  WIDTH  one-cycle pulse, high on the first cycle o_gpio[n] is 1 after being 0.
- o_fall  out  WIDTH  one-cycle pulse, high on the first cycle o_gpio[n] is 0 after being 1.
- o_pend  out  WIDTH  sticky pending flags.
- o_irq  out  1  OR of o_pend.
- o_glitch_cnt  out  8*WIDTH  per-bit glitch counters, bit n at [8n+7:8n]. Only active with the optional feature.

Behaviour:
- Reset values:
  - All flops clear to 0: sync stages, counters, level, level-delayed, pending, glitch counters.
  - Hence o_gpio=0, o_rise=0, o_fall=0, o_pend=0, o_irq=0, o_glitch_cnt=0.
- Synchronizer: s1<=i_pad; s2<=s1. No logic between s1 and s2.
- Debounce, evaluated independently per bit each cycle:
  - If s2==lvl: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: lvl<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Latency: a pad change held stable and sampled at edge k appears on o_gpio after edge k+1+DEBOUNCE_CYCLES, i.e. 18 cycles at default.
- DEBOUNCE_CYCLES=1 gives a pure 2-flop synchronizer plus 1 cycle (3-cycle latency).
- Any mismatch interrupted by a match cycle restarts the count from 0. Pulses shorter than DEBOUNCE_CYCLES never reach o_gpio.
- Edge detect:
  - lvl_d<=lvl.
  - o_rise=lvl&~lvl_d.
  - o_fall=~lvl&lvl_d.
  - Both are combinational from flops, with no gaps or duplicates.
- Pending flag, per bit, next value = (pend & ~i_pend_clr) | (o_rise&i_rise_en) | (o_fall&i_fall_en).
  - If set and clear occur in the same cycle, set wins, so no event is lost.
  - Clearing a flag that is already 0 has no effect.
- o_irq: combinational OR of pend registers. It falls the cycle after the last flag is cleared.
- Enables only gate flag setting. Changing an enable never alters an already-set flag, and o_rise/o_fall pulse regardless of the enables.
- Reset mid-operation clears everything immediately. If a pad is held at 1 through reset, o_gpio rises 2+DEBOUNCE_CYCLES cycles after rst_n deasserts, and that rise is a legitimate event.
- No combinational path from any input to any output except through flops. The i_pend_clr path is registered via pend.

Optional Feature:
- Macro: ALTUSOC_GPIO_GLITCH_CNT_EN.
- Defined:
  - Per-bit 8-bit glitch counter increments when s2==lvl while cnt!=0, i.e. an aborted debounce attempt.
  - Saturates at 255 and is cleared only by reset.
  - Drives o_glitch_cnt.
- Undefined:
  - Counter logic is not generated.
  - o_glitch_cnt is tied to 0.
  - Port list is unchanged.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=16):
- Reset released with i_pad=4'b0000 -> o_gpio=0, o_pend=0, o_irq=0 for 100 cycles.
- Raise i_pad[0] at cycle 10 and hold, with i_rise_en=4'b0001:
  - o_gpio[0] rises exactly 18 cycles later.
  - o_rise[0] pulses for 1 cycle, then o_pend[0]=1 and o_irq=1.
  - Pulse i_pend_clr[0] -> o_pend[0]=0 and o_irq=0 the next cycle.
- 10-cycle high glitch on i_pad[1] -> o_gpio[1] stays 0 and no o_rise.
  - With the macro defined: o_glitch_cnt[15:8]=1.
  - Repeat 300 times -> counter reads 255.
- i_pend_clr[2] asserted in the same cycle o_fall[2] pulses, with i_fall_en[2]=1 -> o_pend[2] remains 1.
- Pad [3] held at 1, rst_n pulsed low mid-debounce (cnt=7):
  - All outputs read 0 during reset.
  - o_gpio[3] rises 18 cycles after deassert.
- Loopback through the SoC core, with GPIO out driving i_pad[0] via bench delay -> the core reads back the written level after 18 cycles of added latency.
